// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared encodings for the 5-stage MIPS hazard controller: operand forwarding
// source selects and the exception-flush FSM states.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  // Operand source select driven onto fwd_a_ctrl / fwd_b_ctrl
  localparam logic [1:0] FWD_RF      = 2'b00;  // register file read
  localparam logic [1:0] FWD_EXE_ALU = 2'b01;  // ALU result in EXE
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;  // ALU result in MEM
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;  // load data in MEM

  // Exception FSM: FLUSH lasts exactly one cycle
  typedef enum logic {
    EXC_IDLE  = 1'b0,
    EXC_FLUSH = 1'b1
  } exc_state_e;

endpackage

// File: rtl/hz_down_counter.sv
// -----------------------------------------------------------------------------
// hz_down_counter
// Loadable saturating down-counter with zero flag.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset (counter -> 0)
//   clr_i      : synchronous clear, highest priority
//   load_i     : load load_val_i
//   load_val_i : value to load
//   dec_i      : decrement by one when nonzero (deassert to hold)
//   zero_o     : counter equals zero
// -----------------------------------------------------------------------------
module hz_down_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard / pipeline control for a 5-stage MIPS pipeline: operand forwarding,
// load-use and multiply/divide stalls, branch flush, one-cycle exception flush
// and debug halt / single-step.
//   clk, rst (async, active-low)
//   id_*            : ID source registers and decode flags
//   exe_/mem_/wb_*  : destination register, write enable and load flag per stage
//   branch_taken, mdu_start, exc_req, debug_en, debug_step : control requests
//   fwd_a_ctrl, fwd_b_ctrl, fwd_m : forwarding selects
//   <stage>_en / <stage>_rst       : stage enables and stage flushes
//   mdu_busy, exc_redirect         : status
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic              id_mdu_use,
  input  logic [REG_AW-1:0] exe_wb_addr,
  input  logic [REG_AW-1:0] mem_wb_addr,
  input  logic [REG_AW-1:0] wb_wb_addr,
  input  logic              exe_wb_wen,
  input  logic              mem_wb_wen,
  input  logic              wb_wb_wen,
  input  logic              exe_is_load,
  input  logic              mem_is_load,
  input  logic              branch_taken,
  input  logic              mdu_start,
  input  logic              exc_req,
  input  logic              debug_en,
  input  logic              debug_step,
  output logic [1:0]        fwd_a_ctrl,
  output logic [1:0]        fwd_b_ctrl,
  output logic              fwd_m,
  output logic              if_en,
  output logic              if_rst,
  output logic              id_en,
  output logic              id_rst,
  output logic              exe_en,
  output logic              exe_rst,
  output logic              mem_en,
  output logic              mem_rst,
  output logic              wb_en,
  output logic              wb_rst,
  output logic              mdu_busy,
  output logic              exc_redirect
);

  localparam int SCW = $clog2(LOAD_LAT + 1);
  localparam int MCW = $clog2(MDU_LAT + 1);

  exc_state_e state_q;
  logic       exc_redirect_q;
  logic       step_prev_q;

  logic load_hz, stall, step_edge, halt, flushing;
  logic stall_zero, mdu_zero;

  // EXE beats MEM; register 0 is hard-wired so it never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              e_wen,
    input logic [REG_AW-1:0] e_addr,
    input logic              m_wen,
    input logic [REG_AW-1:0] m_addr,
    input logic              m_ld
  );
    if (e_wen && (e_addr != '0) && (e_addr == src)) begin
      return FWD_EXE_ALU;
    end else if (m_wen && (m_addr != '0) && (m_addr == src)) begin
      return m_ld ? FWD_MEM_LD : FWD_MEM_ALU;
    end
    return FWD_RF;
  endfunction

  assign fwd_a_ctrl = fwd_sel(id_rs_addr, exe_wb_wen, exe_wb_addr,
                              mem_wb_wen, mem_wb_addr, mem_is_load);
  assign fwd_b_ctrl = fwd_sel(id_rt_addr, exe_wb_wen, exe_wb_addr,
                              mem_wb_wen, mem_wb_addr, mem_is_load);

  // A store only needs the loaded value in MEM, so its rt dependency is
  // resolved by forwarding into the store-data path instead of stalling.
  assign fwd_m = exe_is_load && exe_wb_wen && (exe_wb_addr != '0) &&
                 id_is_store && id_rt_used && (id_rt_addr == exe_wb_addr);

  assign load_hz = exe_is_load && exe_wb_wen && (exe_wb_addr != '0) &&
                   ((id_rs_used && (id_rs_addr == exe_wb_addr)) ||
                    (id_rt_used && !id_is_store && (id_rt_addr == exe_wb_addr)));

  assign mdu_busy  = !mdu_zero;
  assign stall     = load_hz || !stall_zero || (id_mdu_use && mdu_busy);
  assign step_edge = debug_step && !step_prev_q;
  assign halt      = debug_en && !step_edge;
  assign flushing  = (state_q == EXC_FLUSH);

  // Clearing already on the exc_req cycle makes stall_cnt read 0 throughout
  // the FLUSH cycle and drops any stall the flushed load had started.
  hz_down_counter #(.W(SCW)) u_stall_cnt (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (flushing || exc_req),
    .load_i     (load_hz && !halt),
    .load_val_i (SCW'(LOAD_LAT - 1)),
    .dec_i      (!halt),
    .zero_o     (stall_zero)
  );

  hz_down_counter #(.W(MCW)) u_mdu_cnt (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (1'b0),
    .load_i     (mdu_start && !halt),
    .load_val_i (MCW'(MDU_LAT)),
    .dec_i      (!halt),
    .zero_o     (mdu_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= EXC_IDLE;
      exc_redirect_q <= 1'b0;
    end else begin
      case (state_q)
        EXC_IDLE: begin
          if (exc_req) begin
            state_q        <= EXC_FLUSH;
            exc_redirect_q <= 1'b1;
          end
        end
        EXC_FLUSH: begin
          state_q        <= EXC_IDLE;
          exc_redirect_q <= 1'b0;
        end
        default: begin
          state_q        <= EXC_IDLE;
          exc_redirect_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= debug_step;
    end
  end

  assign exc_redirect = exc_redirect_q;

  always_comb begin
    if_en   = 1'b1;
    id_en   = 1'b1;
    exe_en  = 1'b1;
    mem_en  = 1'b1;
    wb_en   = 1'b1;
    if_rst  = 1'b0;
    id_rst  = 1'b0;
    exe_rst = 1'b0;
    mem_rst = 1'b0;
    wb_rst  = 1'b0;
    if (!rst) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (flushing) begin
      // WB holds an older, non-excepting instruction and is allowed to retire
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
    end else if (halt) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (stall) begin
      // Hold IF/ID, inject a bubble into EXE, let older stages drain
      if_en   = 1'b0;
      id_en   = 1'b0;
      exe_rst = 1'b1;
    end else if (branch_taken) begin
      id_rst = 1'b1;
    end
  end

endmodule
